// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares OTTER memory port 2 between the CPU LSU and crypto DMA.
// Fixed CPU priority, with the DMA forced ahead after STARVE_LIMIT CPU grants.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [31:0] CPU_ADDR,
  input  logic [31:0] CPU_DIN,
  input  logic [1:0]  CPU_SIZE,
  input  logic        CPU_SIGN,
  output logic        CPU_GNT,
  output logic        CPU_RVALID,
  output logic [31:0] CPU_RDATA,
  input  logic        DMA_REQ,
  input  logic        DMA_WE,
  input  logic [31:0] DMA_ADDR,
  input  logic [31:0] DMA_DIN,
  input  logic [1:0]  DMA_SIZE,
  input  logic        DMA_SIGN,
  output logic        DMA_GNT,
  output logic        DMA_RVALID,
  output logic [31:0] DMA_RDATA,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_WRITE2,
  output logic        MEM_READ2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2,
  output logic        BUSY
);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             own_dma;
  logic [31:0]      lat_addr;
  logic [1:0]       lat_size;
  logic             lat_sign;

  logic        idle;
  logic        dma_win;
  logic        cpu_win;
  logic        any_win;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_din;
  logic [1:0]  win_size;
  logic        win_sign;

  assign idle    = (state == IDLE);
  assign dma_win = idle && DMA_REQ
                   && (!CPU_REQ || cnt == LIMIT);
  assign cpu_win = idle && CPU_REQ && !dma_win;
  assign any_win = dma_win || cpu_win;

  always_comb begin
    win_we   = 1'b0;
    win_addr = '0;
    win_din  = '0;
    win_size = '0;
    win_sign = 1'b0;
    unique case (1'b1)
      dma_win: begin
        win_we   = DMA_WE;
        win_addr = DMA_ADDR;
        win_din  = DMA_DIN;
        win_size = DMA_SIZE;
        win_sign = DMA_SIGN;
      end
      cpu_win: begin
        win_we   = CPU_WE;
        win_addr = CPU_ADDR;
        win_din  = CPU_DIN;
        win_size = CPU_SIZE;
        win_sign = CPU_SIGN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      cnt      <= '0;
      own_dma  <= 1'b0;
      lat_addr <= '0;
      lat_size <= '0;
      lat_sign <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // cpu_win is the only way to get here with DMA_REQ high
          if (!DMA_REQ || dma_win)
            cnt <= '0;
          else if (cnt != LIMIT)
            cnt <= cnt + 1'b1;
          if (any_win && !win_we) begin
            state    <= RD_WAIT;
            own_dma  <= dma_win;
            lat_addr <= win_addr;
            lat_size <= win_size;
            lat_sign <= win_sign;
          end
        end
        RD_WAIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // reset gating keeps every output at 0 while RST_N is low
  always_comb begin
    CPU_GNT    = 1'b0;
    CPU_RVALID = 1'b0;
    CPU_RDATA  = '0;
    DMA_GNT    = 1'b0;
    DMA_RVALID = 1'b0;
    DMA_RDATA  = '0;
    MEM_ADDR2  = '0;
    MEM_DIN2   = '0;
    MEM_WRITE2 = 1'b0;
    MEM_READ2  = 1'b0;
    MEM_SIZE   = '0;
    MEM_SIGN   = 1'b0;
    BUSY       = 1'b0;
    if (RST_N) begin
      unique case (state)
        IDLE: begin
          if (any_win) begin
            CPU_GNT    = cpu_win;
            DMA_GNT    = dma_win;
            MEM_ADDR2  = win_addr;
            MEM_DIN2   = win_din;
            MEM_SIZE   = win_size;
            MEM_SIGN   = win_sign;
            MEM_WRITE2 = win_we;
            MEM_READ2  = !win_we;
          end
        end
        RD_WAIT: begin
          BUSY      = 1'b1;
          MEM_ADDR2 = lat_addr;
          MEM_SIZE  = lat_size;
          MEM_SIGN  = lat_sign;
          if (own_dma) begin
            DMA_RVALID = 1'b1;
            DMA_RDATA  = MEM_DOUT2;
          end else begin
            CPU_RVALID = 1'b1;
            CPU_RDATA  = MEM_DOUT2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed steps plus randomized traffic
// against a transaction-level reference model and a byte memory.
module tb_mem_port_arbiter;

  localparam int LIM = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CPU_REQ, CPU_WE, CPU_SIGN;
  logic [31:0] CPU_ADDR, CPU_DIN;
  logic [1:0]  CPU_SIZE;
  logic        CPU_GNT, CPU_RVALID;
  logic [31:0] CPU_RDATA;
  logic        DMA_REQ, DMA_WE, DMA_SIGN;
  logic [31:0] DMA_ADDR, DMA_DIN;
  logic [1:0]  DMA_SIZE;
  logic        DMA_GNT, DMA_RVALID;
  logic [31:0] DMA_RDATA;
  logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
  logic        MEM_WRITE2, MEM_READ2, MEM_SIGN, BUSY;
  logic [1:0]  MEM_SIZE;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR),
    .CPU_DIN(CPU_DIN), .CPU_SIZE(CPU_SIZE), .CPU_SIGN(CPU_SIGN),
    .CPU_GNT(CPU_GNT), .CPU_RVALID(CPU_RVALID), .CPU_RDATA(CPU_RDATA),
    .DMA_REQ(DMA_REQ), .DMA_WE(DMA_WE), .DMA_ADDR(DMA_ADDR),
    .DMA_DIN(DMA_DIN), .DMA_SIZE(DMA_SIZE), .DMA_SIGN(DMA_SIGN),
    .DMA_GNT(DMA_GNT), .DMA_RVALID(DMA_RVALID), .DMA_RDATA(DMA_RDATA),
    .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
    .MEM_WRITE2(MEM_WRITE2), .MEM_READ2(MEM_READ2),
    .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
    .MEM_DOUT2(MEM_DOUT2), .BUSY(BUSY)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  size;
    logic        sign;
  } txn_t;

  function automatic int nb(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ld_val(
    input logic [31:0] w, input logic [1:0] off,
    input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0:    return sg ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    return sg ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // memory device: 64 bytes, address bits [5:0], 1-cycle read
  logic [7:0]  dev_mem [64] = '{default: 8'h00};
  logic [31:0] rd_word = '0;

  always @(posedge CLK) begin
    if (MEM_WRITE2)
      for (int k = 0; k < 4; k++)
        if (k < nb(MEM_SIZE))
          dev_mem[6'(MEM_ADDR2[5:0] + 6'(k))] <= MEM_DIN2[8*k +: 8];
    if (MEM_READ2)
      rd_word <= {dev_mem[{MEM_ADDR2[5:2], 2'd3}],
                  dev_mem[{MEM_ADDR2[5:2], 2'd2}],
                  dev_mem[{MEM_ADDR2[5:2], 2'd1}],
                  dev_mem[{MEM_ADDR2[5:2], 2'd0}]};
  end

  assign MEM_DOUT2 = ld_val(rd_word, MEM_ADDR2[1:0], MEM_SIZE, MEM_SIGN);

  logic [7:0] ref_mem [64];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic cpu_set(input logic r, input logic w,
    input logic [31:0] a, input logic [31:0] d,
    input logic [1:0] s, input logic sg);
    CPU_REQ = r; CPU_WE = w; CPU_ADDR = a;
    CPU_DIN = d; CPU_SIZE = s; CPU_SIGN = sg;
  endtask

  task automatic dma_set(input logic r, input logic w,
    input logic [31:0] a, input logic [31:0] d,
    input logic [1:0] s, input logic sg);
    DMA_REQ = r; DMA_WE = w; DMA_ADDR = a;
    DMA_DIN = d; DMA_SIZE = s; DMA_SIGN = sg;
  endtask

  function automatic txn_t rnd_txn();
    txn_t t;
    logic [31:0] a;
    t.we   = 1'($urandom % 2);
    t.size = 2'($urandom % 3);
    a = 32'($urandom % 64);
    if (t.size == 2'd1) a[0] = 1'b0;
    if (t.size == 2'd2) a[1:0] = 2'b00;
    t.addr = (($urandom % 4) == 0) ? (32'h1100_0000 | a) : a;
    t.din  = $urandom;
    t.sign = 1'($urandom % 2);
    return t;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_mem[{a[5:2], 2'd3}], ref_mem[{a[5:2], 2'd2}],
            ref_mem[{a[5:2], 2'd1}], ref_mem[{a[5:2], 2'd0}]};
  endfunction

  initial begin
    txn_t cp, dp, t;
    bit   cpend, dpend, busy, own_d, dw, cw;
    int   m_cnt;
    logic [31:0] exp_rd;

    cpu_set(0, 0, 0, 0, 0, 0);
    dma_set(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    // requests during reset must not be granted
    cpu_set(1, 0, 32'h40, 0, 2, 0);
    dma_set(1, 1, 32'h44, 32'h1, 2, 0);
    smp();
    chk("rst_cpu_gnt", CPU_GNT, 0);
    chk("rst_dma_gnt", DMA_GNT, 0);
    chk("rst_read", MEM_READ2, 0);
    chk("rst_write", MEM_WRITE2, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_addr", MEM_ADDR2, 0);
    tick();
    cpu_set(0, 0, 0, 0, 0, 0);
    dma_set(0, 0, 0, 0, 0, 0);
    RST_N = 1'b1;

    // preload 0xDEADBEEF at 0x100 by a CPU store
    cpu_set(1, 1, 32'h100, 32'hDEAD_BEEF, 2, 0);
    smp();
    chk("pre_gnt", CPU_GNT, 1);
    chk("pre_wr", MEM_WRITE2, 1);
    chk("pre_din", MEM_DIN2, 32'hDEAD_BEEF);
    tick();

    // test 1: CPU load word
    cpu_set(1, 0, 32'h100, 0, 2, 0);
    smp();
    chk("t1_gnt", CPU_GNT, 1);
    chk("t1_rd", MEM_READ2, 1);
    chk("t1_busy0", BUSY, 0);
    chk("t1_rv0", CPU_RVALID, 0);
    tick();
    CPU_REQ = 0;
    smp();
    chk("t1_rvalid", CPU_RVALID, 1);
    chk("t1_rdata", CPU_RDATA, 32'hDEAD_BEEF);
    chk("t1_addr", MEM_ADDR2, 32'h100);
    chk("t1_busy", BUSY, 1);
    chk("t1_nognt", CPU_GNT, 0);
    chk("t1_rd2", MEM_READ2, 0);
    tick();
    smp();
    chk("t1_busy2", BUSY, 0);
    chk("t1_rv2", CPU_RVALID, 0);
    tick();

    // test 2: competing stores, pattern C,C,C,C,D
    cpu_set(1, 1, 32'h20, 32'h1111_1111, 2, 0);
    dma_set(1, 1, 32'h30, 32'h2222_2222, 2, 0);
    for (int i = 0; i < 10; i++) begin
      smp();
      chk($sformatf("t2_dgnt%0d", i), DMA_GNT, ((i % 5) == 4) ? 1 : 0);
      chk($sformatf("t2_cgnt%0d", i), CPU_GNT, ((i % 5) == 4) ? 0 : 1);
      chk($sformatf("t2_wr%0d", i), MEM_WRITE2, 1);
      tick();
    end

    // test 3: DMA lbu at 0x203 of 0x80FF1234
    cpu_set(0, 0, 0, 0, 0, 0);
    dma_set(1, 1, 32'h200, 32'h80FF_1234, 2, 0);
    smp();
    chk("t3_pre_gnt", DMA_GNT, 1);
    tick();
    dma_set(1, 0, 32'h203, 0, 0, 1);
    smp();
    chk("t3_gnt", DMA_GNT, 1);
    chk("t3_rd", MEM_READ2, 1);
    tick();
    DMA_REQ = 0;
    smp();
    chk("t3_rvalid", DMA_RVALID, 1);
    chk("t3_rdata", DMA_RDATA, 32'h0000_0080);
    chk("t3_size", MEM_SIZE, 0);
    chk("t3_sign", MEM_SIGN, 1);
    chk("t3_cpu_rv", CPU_RVALID, 0);
    chk("t3_cpu_rd", CPU_RDATA, 0);
    tick();

    // test 4: DMA raised during RD_WAIT waits one cycle
    cpu_set(1, 0, 32'h100, 0, 2, 0);
    smp();
    chk("t4_cgnt", CPU_GNT, 1);
    tick();
    CPU_REQ = 0;
    dma_set(1, 1, 32'h8, 32'h55, 2, 0);
    smp();
    chk("t4_dgnt_wait", DMA_GNT, 0);
    chk("t4_busy", BUSY, 1);
    chk("t4_rdata", CPU_RDATA, 32'h80FF_1234);
    tick();
    smp();
    chk("t4_dgnt", DMA_GNT, 1);
    chk("t4_wr", MEM_WRITE2, 1);
    chk("t4_addr", MEM_ADDR2, 32'h8);
    tick();
    DMA_REQ = 0;

    // test 5: reset asserted mid read
    cpu_set(1, 0, 32'h8, 0, 2, 0);
    smp();
    chk("t5_gnt", CPU_GNT, 1);
    tick();
    #2;
    RST_N = 1'b0;
    #1;
    chk("t5_rv", CPU_RVALID, 0);
    chk("t5_busy", BUSY, 0);
    chk("t5_addr", MEM_ADDR2, 0);
    chk("t5_gnt_rst", CPU_GNT, 0);
    chk("t5_size", MEM_SIZE, 0);
    tick();
    RST_N = 1'b1;
    smp();
    chk("t5_regnt", CPU_GNT, 1);
    chk("t5_rd", MEM_READ2, 1);
    tick();
    CPU_REQ = 0;
    smp();
    chk("t5_rvalid", CPU_RVALID, 1);
    chk("t5_rdata", CPU_RDATA, 32'h55);
    tick();

    // test 6: DMA_REQ gap restarts the starvation count
    cpu_set(1, 1, 32'h30, 32'h1, 2, 0);
    dma_set(1, 1, 32'h34, 32'h2, 2, 0);
    for (int i = 0; i < 9; i++) begin
      DMA_REQ = (i != 3);
      smp();
      chk($sformatf("t6_dgnt%0d", i), DMA_GNT, (i == 8) ? 1 : 0);
      chk($sformatf("t6_cgnt%0d", i), CPU_GNT, (i == 8) ? 0 : 1);
      tick();
    end
    cpu_set(0, 0, 0, 0, 0, 0);
    dma_set(0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // randomized traffic against the reference model
    ref_mem = dev_mem;
    cpend = 0; dpend = 0; busy = 0; own_d = 0;
    m_cnt = 0; exp_rd = '0;
    cp = rnd_txn();
    dp = rnd_txn();
    for (int c = 0; c < 3000; c++) begin
      if (!cpend && ($urandom % 3) == 0) begin
        cp = rnd_txn(); cpend = 1;
      end else if (cpend && ($urandom % 16) == 0) begin
        cpend = 0;
      end
      if (!dpend && ($urandom % 3) == 0) begin
        dp = rnd_txn(); dpend = 1;
      end else if (dpend && ($urandom % 16) == 0) begin
        dpend = 0;
      end
      cpu_set(cpend, cp.we, cp.addr, cp.din, cp.size, cp.sign);
      dma_set(dpend, dp.we, dp.addr, dp.din, dp.size, dp.sign);
      smp();
      if (!busy) begin
        dw = dpend && (!cpend || m_cnt == LIM);
        cw = cpend && !dw;
        t  = dw ? dp : cp;
        chk("r_cgnt", CPU_GNT, cw);
        chk("r_dgnt", DMA_GNT, dw);
        chk("r_wr", MEM_WRITE2, (dw || cw) && t.we);
        chk("r_rd", MEM_READ2, (dw || cw) && !t.we);
        chk("r_busy", BUSY, 0);
        chk("r_rv", {CPU_RVALID, DMA_RVALID}, 0);
        if (dw || cw) begin
          chk("r_addr", MEM_ADDR2, t.addr);
          if (t.we) begin
            chk("r_din", MEM_DIN2, t.din);
            for (int k = 0; k < nb(t.size); k++)
              ref_mem[6'(t.addr[5:0] + 6'(k))] = t.din[8*k +: 8];
          end else begin
            busy   = 1;
            own_d  = dw;
            exp_rd = ld_val(ref_word(t.addr), t.addr[1:0],
                            t.size, t.sign);
          end
        end
        if (!dpend || dw) m_cnt = 0;
        else if (m_cnt < LIM) m_cnt++;
        if (dw) dpend = 0;
        if (cw) cpend = 0;
      end else begin
        chk("r_wbusy", BUSY, 1);
        chk("r_wgnt", {CPU_GNT, DMA_GNT}, 0);
        chk("r_wmem", {MEM_WRITE2, MEM_READ2}, 0);
        chk("r_crv", CPU_RVALID, !own_d);
        chk("r_drv", DMA_RVALID, own_d);
        chk("r_crd", CPU_RDATA, own_d ? 32'h0 : exp_rd);
        chk("r_drd", DMA_RDATA, own_d ? exp_rd : 32'h0);
        busy = 0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
